mac_array_ctrl: RTL and testbench

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

---
 rtl/mac_pkg.sv | 33 +++
 rtl/ctrl_counter.sv | 27 ++
 rtl/mac_array_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mac_array_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array controller.
//   state_t  : controller FSM states
//   INST_*   : array instruction codes driven on inst_w
//   inst_of  : instruction implied by a state (registered once in the top)
//   imax     : elaboration-time helper for counter sizing
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KLOAD = 3'd1,
        S_KWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    function automatic logic [1:0] inst_of(input state_t s);
        case (s)
            S_KLOAD: return INST_KLOAD;
            S_EXEC:  return INST_EXEC;
            default: return INST_IDLE;
        endcase
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_counter.sv
// Loadable up-counter with terminal-count compare.
//   clk, reset (async, active-low)
//   load/load_val : synchronous load, has priority over en
//   en            : increment by one
//   term          : compare value; tc = (cnt == term)
module ctrl_counter #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [w-1:0] load_val,
    input  logic         en,
    input  logic [w-1:0] term,
    output logic [w-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for a row x col MAC array: loads the kernel, waits for the
// instruction skew to settle, streams activations and collects outputs.
//   clk, reset (async, active-low)
//   start, cfg_kbase, cfg_abase, cfg_len, cfg_dmode : job request/config
//   valid[col-1:0]     : per-column output valid from the array
//   mem_ren, mem_addr  : input memory read port (1-cycle read latency)
//   inst_w, data_mode  : array instruction (aligned with read data) and mode
//   psum_wen, psum_addr: output memory write strobe / row index
//   busy, done, err    : status; err is a sticky drain timeout
module mac_array_ctrl
    import mac_pkg::*;
#(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int aw        = 11,
    parameter int lw        = 8,
    parameter int drain_max = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [aw-1:0] cfg_kbase,
    input  logic [aw-1:0] cfg_abase,
    input  logic [lw-1:0] cfg_len,
    input  logic          cfg_dmode,
    input  logic [col-1:0] valid,
    output logic          mem_ren,
    output logic [aw-1:0] mem_addr,
    output logic [1:0]    inst_w,
    output logic          data_mode,
    output logic          psum_wen,
    output logic [lw-1:0] psum_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Phase counter must hold the longest phase: col, row, cfg_len or drain_max.
    localparam int pw = imax(imax(lw, $clog2(drain_max + 1)),
                             imax($clog2(col + 1), $clog2(row + 1)));

    state_t        state, state_n;
    logic [aw-1:0] kbase_q, abase_q;
    logic [lw-1:0] len_q;
    logic          accept, err_set;
    logic [pw-1:0] ph_cnt, ph_term;
    logic          ph_tc, ph_load, ph_en;
    logic [lw-1:0] out_cnt;
    logic          out_tc, wr_ok, last_wr;

    assign accept = (state == S_IDLE) && start;

    // Writes stop once all cfg_len outputs are in; late pulses are dropped.
    assign wr_ok   = ((state == S_EXEC) || (state == S_DRAIN)) && valid[col-1] && !out_tc;
    assign last_wr = wr_ok && (out_cnt == len_q - lw'(1));

    // Phase counter restarts from zero on every state change.
    assign ph_load = (state_n != state);
    assign ph_en   = (state != S_IDLE);

    always_comb begin
        ph_term = '0;
        case (state)
            S_KLOAD: ph_term = pw'(col - 1);
            S_KWAIT: ph_term = pw'(row - 1);
            S_EXEC:  ph_term = pw'(len_q) - pw'(1);
            S_DRAIN: ph_term = pw'(drain_max - 1);
            default: ph_term = '0;
        endcase
    end

    ctrl_counter #(.w(pw)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load),
        .load_val ({pw{1'b0}}),
        .en       (ph_en),
        .term     (ph_term),
        .cnt      (ph_cnt),
        .tc       (ph_tc)
    );

    ctrl_counter #(.w(lw)) u_outcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val ({lw{1'b0}}),
        .en       (wr_ok),
        .term     (len_q),
        .cnt      (out_cnt),
        .tc       (out_tc)
    );

    always_comb begin
        state_n = state;
        err_set = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = S_KLOAD;
            S_KLOAD: if (ph_tc) state_n = S_KWAIT;
            // Broadcast mode needs no skew settling, so a single wait cycle.
            S_KWAIT: if (data_mode || ph_tc)
                         state_n = (len_q == '0) ? S_DONE : S_EXEC;
            S_EXEC:  if (ph_tc) state_n = S_DRAIN;
            S_DRAIN: begin
                if (out_tc || last_wr) begin
                    state_n = S_DONE;
                end else if (ph_tc) begin
                    state_n = S_DONE;
                    err_set = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ren  = 1'b0;
        mem_addr = '0;
        case (state)
            S_KLOAD: begin
                mem_ren  = 1'b1;
                mem_addr = kbase_q + aw'(ph_cnt);
            end
            S_EXEC: begin
                mem_ren  = 1'b1;
                mem_addr = abase_q + aw'(ph_cnt);
            end
            default: ;
        endcase
    end

    assign psum_wen  = wr_ok;
    assign psum_addr = out_cnt;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            inst_w    <= INST_IDLE;
            kbase_q   <= '0;
            abase_q   <= '0;
            len_q     <= '0;
            data_mode <= 1'b0;
            err       <= 1'b0;
        end else begin
            state  <= state_n;
            // One stage late so the instruction lines up with read data.
            inst_w <= inst_of(state);
            if (accept) begin
                kbase_q   <= cfg_kbase;
                abase_q   <= cfg_abase;
                len_q     <= cfg_len;
                data_mode <= cfg_dmode;
            end
            if (accept)       err <= 1'b0;
            else if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
module tb_mac_array_ctrl;

    typedef struct packed {
        logic [10:0] addr;
        logic [1:0]  inst;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] cfg_kbase = '0, cfg_abase = '0;
    logic [7:0]  cfg_len = '0;
    logic        cfg_dmode = 1'b0;
    logic [7:0]  valid = '0;
    logic        mem_ren, data_mode, psum_wen, busy, done, err;
    logic [10:0] mem_addr;
    logic [1:0]  inst_w;
    logic [7:0]  psum_addr;

    mac_array_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_kbase(cfg_kbase), .cfg_abase(cfg_abase), .cfg_len(cfg_len),
        .cfg_dmode(cfg_dmode), .valid(valid),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .inst_w(inst_w),
        .data_mode(data_mode), .psum_wen(psum_wen), .psum_addr(psum_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    // Scoreboard queues, filled when a job is launched.
    rd_t  rd_q[$];
    int   wr_q[$];
    logic done_q[$];

    // Monitor state shared with the job driver.
    logic       mon_en = 1'b0;
    logic [1:0] pend_inst = 2'b00;
    rd_t        mon_it;
    int         k_cnt, x_cnt, last_k, first_x, last_x, done_cyc;
    bit         x_seen, done_seen;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("inst_w", 32'(inst_w), 32'(pend_inst));
            pend_inst = 2'b00;
            if (mem_ren) begin
                if (rd_q.size() == 0) chk("rd_unexp", 32'd1, 32'd0);
                else begin
                    mon_it = rd_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(mon_it.addr));
                    pend_inst = mon_it.inst;
                    if (mon_it.inst == 2'b01) begin
                        last_k = cyc;
                        k_cnt++;
                    end else begin
                        if (!x_seen) first_x = cyc;
                        x_seen = 1'b1;
                        last_x = cyc;
                        x_cnt++;
                    end
                end
            end
            if (psum_wen) begin
                if (wr_q.size() == 0) chk("wr_unexp", 32'd1, 32'd0);
                else chk("psum_addr", 32'(psum_addr), 32'(wr_q.pop_front()));
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexp", 32'd1, 32'd0);
                else chk("err_at_done", 32'(err), 32'(done_q.pop_front()));
                chk("busy_at_done", 32'(busy), 32'd1);
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
        end
    end

    // One job: kernel/activation bases, length, mode, number of valid pulses
    // and their spacing, expected err, optional start during drain, optional
    // reset after abort_x activation reads.
    task automatic job(input logic [10:0] kb, input logic [10:0] ab, input int len,
                       input logic dm, input int np, input int per, input logic eerr,
                       input bit st_drain, input int abort_x);
        int wt, r, nw;
        wt = dm ? 1 : 8;
        nw = (np < len) ? np : len;
        rd_q.delete(); wr_q.delete(); done_q.delete();
        for (int k = 0; k < 8; k++)   rd_q.push_back(rd_t'{kb + 11'(k), 2'b01});
        for (int n = 0; n < len; n++) rd_q.push_back(rd_t'{ab + 11'(n), 2'b10});
        for (int i = 0; i < nw; i++)  wr_q.push_back(i);
        if (abort_x < 0) done_q.push_back(eerr);
        k_cnt = 0; x_cnt = 0; x_seen = 1'b0; done_seen = 1'b0;
        last_k = 0; first_x = 0; last_x = 0; done_cyc = 0;
        pend_inst = 2'b00;
        mon_en = 1'b1;
        @(posedge clk); #1;
        cfg_kbase = kb; cfg_abase = ab; cfg_len = 8'(len); cfg_dmode = dm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        for (int t = 0; t < 300 && !done_seen; t++) begin
            @(posedge clk); #1;
            if (abort_x >= 0 && x_cnt == abort_x) begin
                reset = 1'b0;
                #1;
                chk("rst_mem_ren", 32'(mem_ren), 32'd0);
                chk("rst_mem_addr", 32'(mem_addr), 32'd0);
                chk("rst_inst_w", 32'(inst_w), 32'd0);
                chk("rst_psum_wen", 32'(psum_wen), 32'd0);
                chk("rst_psum_addr", 32'(psum_addr), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_data_mode", 32'(data_mode), 32'd0);
                mon_en = 1'b0;
                valid = '0;
                @(posedge clk); @(posedge clk); #1;
                chk("rst_done", 32'(done), 32'd0);
                reset = 1'b1;
                return;
            end
            valid = '0;
            if (k_cnt == 8) begin
                r = cyc - (last_k + wt + 1);
                if (r >= 0 && (r % per) == 0 && (r / per) < np) valid[7] = 1'b1;
            end
            if (st_drain && x_cnt == len && (cyc - last_x) == 5) begin
                start = 1'b1; cfg_dmode = ~dm; cfg_kbase = 11'h7ff; cfg_len = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        if (!done_seen) chk("job_timeout", 32'd0, 32'd1);
        valid = '0; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("err_sticky", 32'(err), 32'(eerr));
        chk("data_mode", 32'(data_mode), 32'(dm));
        chk("rd_left", 32'(rd_q.size()), 32'd0);
        chk("wr_left", 32'(wr_q.size()), 32'd0);
        chk("done_left", 32'(done_q.size()), 32'd0);
        if (len > 0) chk("kwait_len", 32'(first_x - last_k - 1), 32'(wt));
        else         chk("kwait_len0", 32'(done_cyc - last_k - 1), 32'(wt));
        if (eerr) chk("drain_len", 32'(done_cyc - last_x - 1), 32'd64);
        mon_en = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("init_mem_ren", 32'(mem_ren), 32'd0);
        chk("init_inst_w", 32'(inst_w), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        chk("init_psum_wen", 32'(psum_wen), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // kernel at 0x010, 4 outputs spread across exec and drain
        job(11'h010, 11'h100, 4, 1'b0, 4, 2, 1'b0, 1'b0, -1);
        // empty activation set: KWAIT straight to DONE
        job(11'h020, 11'h200, 0, 1'b0, 0, 1, 1'b0, 1'b0, -1);
        // no outputs: drain timeout, plus a start during drain that must be ignored
        job(11'h030, 11'h300, 3, 1'b0, 0, 1, 1'b1, 1'b1, -1);
        // broadcast mode, address wrap, surplus valid pulses; err clears on start
        job(11'h7fc, 11'h7fe, 3, 1'b1, 5, 1, 1'b0, 1'b0, -1);
        // reset in the third exec cycle, then a clean job
        job(11'h040, 11'h050, 6, 1'b0, 0, 1, 1'b0, 1'b0, 2);
        job(11'h100, 11'h180, 5, 1'b0, 5, 3, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
